// File: rtl/dich8led_pkg.sv
// Shared types and constants for the right-to-left LED pattern generator.
package dich8led_pkg;

  typedef enum logic [1:0] {
    CHASE = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } led_state_t;

  localparam int              LED_W       = 8;
  localparam logic [LED_W-1:0] LED_RESET  = 8'h01;
  localparam logic [LED_W-1:0] LED_FULL   = 8'hFF;
  localparam logic [LED_W-1:0] LED_EMPTY  = 8'h00;
  localparam logic [LED_W-1:0] LED_DRAIN0 = 8'hFE;

endpackage

// File: rtl/dich8led_pst_step_prescaler.sv
// Step-rate prescaler: one-cycle tick every DIV enabled clocks; en=0 holds the count.
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dich8led_pst.sv
// Right-to-left 8-LED pattern generator: single-dot chase or fill/drain bar,
// advanced one position per prescaler tick.
module dich8led_pst
  import dich8led_pkg::*;
#(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode,
  output logic [7:0] LED8,
  output logic       step
);

  logic tick;

  step_prescaler #(.DIV(STEP_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  led_state_t       state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;

  // Every mode change restarts the pattern at a single lit LED0.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    step_d  = tick;
    if (tick) begin
      case (state_q)
        CHASE: begin
          if (!mode) begin
            led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          end else begin
            state_d = FILL;
            led_d   = LED_RESET;
          end
        end
        FILL: begin
          if (!mode) begin
            state_d = CHASE;
            led_d   = LED_RESET;
          end else if (led_q == LED_FULL) begin
            state_d = DRAIN;
            led_d   = LED_DRAIN0;
          end else begin
            led_d = {led_q[LED_W-2:0], 1'b1};
          end
        end
        DRAIN: begin
          if (!mode) begin
            state_d = CHASE;
            led_d   = LED_RESET;
          end else if (led_q == LED_EMPTY) begin
            state_d = FILL;
            led_d   = LED_RESET;
          end else begin
            led_d = {led_q[LED_W-2:0], 1'b0};
          end
        end
        default: begin
          state_d = CHASE;
          led_d   = LED_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CHASE;
      led_q   <= LED_RESET;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign LED8 = led_q;
  assign step = step_q;

endmodule
